// File: rtl/dmn_last_seq.sv
// Terminal dmn_* stage: streams a NUM_PARA-word parameter table over valid/ready, then pulses dmn_end.
// Define DMN_LAST_WR_EN for a runtime-writable table (cfg_* ports); otherwise the table is constant PARA_INIT.
module dmn_last_seq #(
  parameter bit                         ZERO      = 1'b0,
  parameter int                         NUM_PARA  = 3,
  parameter int                         PARA_W    = 32,
  parameter logic [NUM_PARA*PARA_W-1:0] PARA_INIT = {32'd8, 32'd2, 32'hff9911},
  localparam int                        IDX_W     = (NUM_PARA > 1) ? $clog2(NUM_PARA) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmn_en,
  output logic              dmn_end,
  output logic              zero,
  output logic              busy,
  output logic [PARA_W-1:0] para_data,
  output logic [IDX_W-1:0]  para_idx,
  output logic              para_valid,
  input  logic              para_ready
`ifdef DMN_LAST_WR_EN
  ,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [PARA_W-1:0] cfg_wdata
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, DONE, WAIT_LOW} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PARA - 1);

  state_t            state_reg, state_next;
  logic              valid_reg, valid_next;
  logic              end_reg, end_next;
  logic              busy_reg, busy_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [PARA_W-1:0] data_reg, data_next;

  logic [PARA_W-1:0] init_word  [NUM_PARA];
  logic [PARA_W-1:0] table_word [NUM_PARA];
  logic [IDX_W-1:0]  rd_idx;
  logic [PARA_W-1:0] rd_word;

  for (genvar gi = 0; gi < NUM_PARA; gi++) begin : g_init
    assign init_word[gi] = PARA_INIT[gi*PARA_W +: PARA_W];
  end

`ifdef DMN_LAST_WR_EN
  logic wr_en;

  // Table is frozen while a burst is in flight; out-of-range addresses are dropped.
  assign wr_en = cfg_we && !busy_reg &&
                 ({{(32-IDX_W){1'b0}}, cfg_addr} < 32'(NUM_PARA));

  for (genvar gi = 0; gi < NUM_PARA; gi++) begin : g_tbl
    logic [PARA_W-1:0] word_reg;
    always_ff @(posedge clk) begin
      if (rst)
        word_reg <= init_word[gi];
      else if (wr_en && cfg_addr == IDX_W'(gi))
        word_reg <= cfg_wdata;
    end
    assign table_word[gi] = word_reg;
  end

  // Forward a same-cycle write so a burst started alongside it sees the new word.
  assign rd_word = (wr_en && cfg_addr == rd_idx) ? cfg_wdata : table_word[rd_idx];
`else
  for (genvar gi = 0; gi < NUM_PARA; gi++) begin : g_tbl
    assign table_word[gi] = init_word[gi];
  end

  assign rd_word = table_word[rd_idx];
`endif

  // Word to load next: index 0 on start, idx+1 while advancing; never wraps.
  assign rd_idx = (state_reg == SEND && idx_reg != LAST_IDX) ? idx_reg + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      end_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      end_reg   <= end_next;
      busy_reg  <= busy_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (dmn_en) begin
          state_next = SEND;
          valid_next = 1'b1;
          idx_next   = '0;
          data_next  = rd_word;
        end
      end
      SEND: begin
        if (valid_reg && para_ready) begin
          if (idx_reg == LAST_IDX) begin
            valid_next = 1'b0;
            state_next = DONE;
          end else begin
            idx_next  = rd_idx;
            data_next = rd_word;
          end
        end
      end
      DONE:     state_next = WAIT_LOW;
      WAIT_LOW: if (!dmn_en) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    end_next  = (state_next == DONE);
    busy_next = (state_next == SEND) || (state_next == DONE);
  end

  assign dmn_end    = end_reg;
  assign busy       = busy_reg;
  assign para_valid = valid_reg;
  assign para_idx   = idx_reg;
  assign para_data  = data_reg;
  assign zero       = ZERO;

endmodule

// File: tb/tb_dmn_last_seq.sv
// Scoreboard bench for dmn_last_seq: default instance plus a NUM_PARA=1 / PARA_W=8 instance.
module tb_dmn_last_seq;

  typedef struct {
    bit          is_end;
    logic [31:0] data;
    logic [1:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, dmn_en, para_ready;
  logic        dmn_end, zero, busy, para_valid;
  logic [31:0] para_data;
  logic [1:0]  para_idx;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;

  logic        en1, rdy1, end1, zero1, busy1, valid1;
  logic [7:0]  data1;
  logic [0:0]  idx1;
  logic        cfg_we1;
  logic [0:0]  cfg_addr1;
  logic [7:0]  cfg_wdata1;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  logic [31:0] tbl [3];

  always #5 clk = ~clk;

  dmn_last_seq u_dut (
    .clk(clk), .rst(rst), .dmn_en(dmn_en), .dmn_end(dmn_end), .zero(zero), .busy(busy),
    .para_data(para_data), .para_idx(para_idx), .para_valid(para_valid), .para_ready(para_ready)
`ifdef DMN_LAST_WR_EN
    , .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
`endif
  );

  dmn_last_seq #(.NUM_PARA(1), .PARA_W(8), .PARA_INIT(8'h5A)) u_dut1 (
    .clk(clk), .rst(rst), .dmn_en(en1), .dmn_end(end1), .zero(zero1), .busy(busy1),
    .para_data(data1), .para_idx(idx1), .para_valid(valid1), .para_ready(rdy1)
`ifdef DMN_LAST_WR_EN
    , .cfg_we(cfg_we1), .cfg_addr(cfg_addr1), .cfg_wdata(cfg_wdata1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else
      $display("[TB] ok   %s: 0x%0h", name, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst();
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, tbl[i], 2'(i)});
    sb.push_back('{1'b1, 32'h0, 2'd0});
  endtask

  // Monitor: every accepted word and every dmn_end cycle consumes one expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (para_valid && para_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL xfer_unexpected: got idx %0d data 0x%0h, expected nothing", para_idx, para_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xfer_kind", 32'(e.is_end), 32'd0);
          chk("xfer_data", para_data, e.data);
          chk("xfer_idx", 32'(para_idx), 32'(e.idx));
        end
      end
      if (dmn_end) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL end_unexpected: got dmn_end=1, expected no pulse");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("end_kind", 32'(e.is_end), 32'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dmn_en = 1'b0; para_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    en1 = 1'b0; rdy1 = 1'b1; cfg_we1 = 1'b0; cfg_addr1 = '0; cfg_wdata1 = '0;
    tbl[0] = 32'hff9911; tbl[1] = 32'd2; tbl[2] = 32'd8;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(para_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_end", 32'(dmn_end), 0);
    chk("rst_idx", 32'(para_idx), 0);
    chk("rst_data", para_data, 0);
    chk("zero", 32'(zero), 0);
    chk("zero1", 32'(zero1), 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic burst with exact cycle timing.
    push_burst();
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    @(negedge clk); chk("t1_w0_valid", 32'(para_valid), 1); chk("t1_w0_idx", 32'(para_idx), 0);
    @(negedge clk); chk("t1_w1_idx", 32'(para_idx), 1);
    @(negedge clk); chk("t1_w2_idx", 32'(para_idx), 2);
    @(negedge clk); chk("t1_end", 32'(dmn_end), 1); chk("t1_end_busy", 32'(busy), 1);
    chk("t1_end_valid", 32'(para_valid), 0);
    @(negedge clk); chk("t1_after_end", 32'(dmn_end), 0); chk("t1_after_busy", 32'(busy), 0);
    repeat (3) tick();
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // Ready pattern 1,0,0,1,1: word idx1 held across the stall.
    push_burst();
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    tick();
    para_ready = 1'b0;
    @(negedge clk); chk("t2_stall_data_a", para_data, 32'd2); chk("t2_stall_idx_a", 32'(para_idx), 1);
    tick();
    @(negedge clk); chk("t2_stall_data_b", para_data, 32'd2); chk("t2_stall_valid", 32'(para_valid), 1);
    tick();
    para_ready = 1'b1;
    repeat (8) tick();
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // Held-high dmn_en gives one burst; a one-cycle drop rearms.
    push_burst();
    dmn_en = 1'b1;
    repeat (20) tick();
    chk("t3_hold_sb_empty", 32'(sb.size()), 0);
    dmn_en = 1'b0;
    tick();
    push_burst();
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    repeat (8) tick();
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Reset while idx1 is presented aborts without dmn_end.
    sb.push_back('{1'b0, tbl[0], 2'd0});
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    tick();
    para_ready = 1'b0;
    @(negedge clk); chk("t4_pre_idx", 32'(para_idx), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(para_valid), 0);
    chk("t4_idx", 32'(para_idx), 0);
    chk("t4_busy", 32'(busy), 0);
    para_ready = 1'b1;
    repeat (5) tick();
    chk("t4_abort_sb_empty", 32'(sb.size()), 0);
    push_burst();
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    repeat (8) tick();
    chk("t4_sb_empty", 32'(sb.size()), 0);

`ifdef DMN_LAST_WR_EN
    // Idle write lands; writes while busy and out-of-range writes are dropped.
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'hABCD;
    tick();
    cfg_addr = 2'd3; cfg_wdata = 32'hDEAD;
    tick();
    cfg_we = 1'b0;
    tbl[1] = 32'hABCD;
    push_burst();
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h1234;
    tick();
    cfg_we = 1'b0;
    repeat (8) tick();
    chk("t5_sb_empty", 32'(sb.size()), 0);
    // Write and start in the same cycle: burst sees the new word 0.
    tbl[0] = 32'h77;
    push_burst();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h77;
    dmn_en = 1'b1;
    tick();
    cfg_we = 1'b0; dmn_en = 1'b0;
    repeat (8) tick();
    chk("t5_same_sb_empty", 32'(sb.size()), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tbl[0] = 32'hff9911; tbl[1] = 32'd2;
    push_burst();
    dmn_en = 1'b1;
    tick();
    dmn_en = 1'b0;
    repeat (8) tick();
    chk("t5_rst_sb_empty", 32'(sb.size()), 0);
`endif

    // Single-word instance.
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    @(negedge clk);
    chk("n1_valid", 32'(valid1), 1);
    chk("n1_data", 32'(data1), 32'h5A);
    chk("n1_idx", 32'(idx1), 0);
    chk("n1_no_end", 32'(end1), 0);
    @(negedge clk);
    chk("n1_end", 32'(end1), 1);
    chk("n1_valid_low", 32'(valid1), 0);
    @(negedge clk);
    chk("n1_end_low", 32'(end1), 0);
    chk("n1_busy_low", 32'(busy1), 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
